period_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous square-wave input in units of the system clock. It is the receiving end of the clock dividers in this design: it takes a divided or external clock, and reports its period, high time, lock status and loss-of-signal on `clk_i`. The block synchronizes the input, detects its edges, and counts `clk_i` cycles between rising edges. Each completed period produces a one-cycle `valid_o` pulse.

---
 rtl/period_meter.sv | 151 +++++++++++++++
 tb/tb_period_meter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// period_meter: measures the period and high time of a slow asynchronous
// square wave in clk_i cycles. It also reports lock status and
// loss-of-signal for that input.
module period_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sig_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             locked_o,
  output logic             lost_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_e;

  logic             sync0_q, sync1_q, sigDly_q;
  logic             rise, fall;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cntInc;
  logic [CNT_W-1:0] hCap_q, hCap_d;
  logic             hSeen_q, hSeen_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             lost_q, lost_d;

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync0_q  <= 1'b0;
      sync1_q  <= 1'b0;
      sigDly_q <= 1'b0;
    end else begin
      sync0_q  <= sig_i;
      sync1_q  <= sync0_q;
      sigDly_q <= sync1_q;
    end
  end

  assign rise   = sync1_q & ~sigDly_q;
  assign fall   = ~sync1_q & sigDly_q;
  assign cntInc = cnt_q + ONE_C;

  // State, counter and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hCap_q   <= '0;
      hSeen_q  <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hCap_q   <= hCap_d;
      hSeen_q  <= hSeen_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
    end
  end

  // Next-state logic; disable overrides every event, and in MEAS a timeout
  // is checked before a lone fall so the counter can never pass TIMEOUT
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hCap_d   = hCap_q;
    hSeen_d  = hSeen_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    lost_d   = lost_q;

    if (!en_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      locked_d = 1'b0;
      lost_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d    = '0;
          locked_d = 1'b0;
          lost_d   = 1'b0;
          state_d  = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_d   = ONE_C;
            hSeen_d = 1'b0;
            lost_d  = 1'b0;
            state_d = MEAS;
          end else if (cnt_q < TIMEOUT_C) begin
            cnt_d = cntInc;
          end else begin
            lost_d = 1'b1;
          end
        end
        MEAS: begin
          if (rise) begin
            period_d = cnt_q;
            high_d   = hSeen_q ? hCap_q : cnt_q;
            valid_d  = 1'b1;
            locked_d = 1'b1;
            cnt_d    = ONE_C;
            hSeen_d  = 1'b0;
          end else if (cnt_q == TIMEOUT_C) begin
            lost_d   = 1'b1;
            locked_d = 1'b0;
            cnt_d    = '0;
            state_d  = ARM;
          end else if (fall) begin
            hCap_d  = cnt_q;
            hSeen_d = 1'b1;
            cnt_d   = cntInc;
          end else begin
            cnt_d = cntInc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign period_o = period_q;
  assign high_o   = high_q;
  assign valid_o  = valid_q;
  assign locked_o = locked_q;
  assign lost_o   = lost_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with TIMEOUT=100. Inputs change on the
// falling clock edge and outputs are sampled 1 time unit after the rising edge.
module tb_period_meter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        sig_i;
  logic [15:0] period_o;
  logic [15:0] high_o;
  logic        valid_o;
  logic        locked_o;
  logic        lost_o;

  int compareCount = 0;
  int failCount    = 0;

  period_meter #(.CNT_W(16), .TIMEOUT(100)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (en_i),
    .sig_i   (sig_i),
    .period_o(period_o),
    .high_o  (high_o),
    .valid_o (valid_o),
    .locked_o(locked_o),
    .lost_o  (lost_o)
  );

  // Free-running system clock, period 10
  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs on the falling edge, then sample after the rise
  task automatic applyStimulus(input logic en, input logic sig);
    @(negedge clk_i);
    en_i  = en;
    sig_i = sig;
    @(posedge clk_i);
    #1;
  endtask

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // All outputs must read zero
  task automatic checkZero(input string tag);
    checkOutput({tag, " period"}, 32'(period_o), 32'd0);
    checkOutput({tag, " high"},   32'(high_o),   32'd0);
    checkOutput({tag, " valid"},  32'(valid_o),  32'd0);
    checkOutput({tag, " locked"}, 32'(locked_o), 32'd0);
    checkOutput({tag, " lost"},   32'(lost_o),   32'd0);
  endtask

  // One input period starting with a rise; that rise is processed 2 calls later (i==2)
  task automatic runPeriod(input string tag, input int hi, input int lo,
                           input logic expValid, input int expP, input int expH,
                           input logic expLocked, input logic expLostBefore);
    for (int i = 0; i < hi + lo; i++) begin
      applyStimulus(1'b1, (i < hi) ? 1'b1 : 1'b0);
      checkOutput({tag, " valid"}, 32'(valid_o), 32'((expValid && i == 2) ? 1 : 0));
      if (i < 2) checkOutput({tag, " lostBefore"}, 32'(lost_o), 32'(expLostBefore));
      if (i == 2) begin
        checkOutput({tag, " locked"}, 32'(locked_o), 32'(expLocked));
        checkOutput({tag, " lost"},   32'(lost_o),   32'd0);
        if (expValid) begin
          checkOutput({tag, " period"}, 32'(period_o), 32'(expP));
          checkOutput({tag, " high"},   32'(high_o),   32'(expH));
        end
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    en_i  = 1'b0;
    sig_i = 1'b0;
    #12;
    checkZero("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Divide-by-2; a rise set at call k is processed at call k+2
    applyStimulus(1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, (k <= 7 && (k % 2) == 1) ? 1'b1 : 1'b0);
      checkOutput("div2 valid", 32'(valid_o), 32'((k == 5 || k == 7 || k == 9) ? 1 : 0));
      checkOutput("div2 lost", 32'(lost_o), 32'd0);
      if (k == 4) checkOutput("div2 notLockedYet", 32'(locked_o), 32'd0);
      if (k == 5 || k == 7 || k == 9) begin
        checkOutput("div2 period", 32'(period_o), 32'd2);
        checkOutput("div2 high",   32'(high_o),   32'd1);
        checkOutput("div2 locked", 32'(locked_o), 32'd1);
      end
    end

    // Divide-by-10, 3 high; first block closes a 4-cycle transitional period
    runPeriod("div10a", 3, 7, 1'b1, 4, 1, 1'b1, 1'b0);
    runPeriod("div10b", 3, 7, 1'b1, 10, 3, 1'b1, 1'b0);
    runPeriod("div10c", 3, 7, 1'b1, 10, 3, 1'b1, 1'b0);

    // Timeout: 7 edges have passed since the last update; loss at edge 100
    for (int n = 8; n <= 102; n++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("timeout lost",   32'(lost_o),   32'((n >= 100) ? 1 : 0));
      checkOutput("timeout locked", 32'(locked_o), 32'((n >= 100) ? 0 : 1));
      checkOutput("timeout valid",  32'(valid_o),  32'd0);
    end
    runPeriod("restart1", 3, 7, 1'b0, 0, 0, 1'b0, 1'b1);
    runPeriod("restart2", 3, 7, 1'b1, 10, 3, 1'b1, 1'b0);

    // Disable in the same cycle the rise is processed
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("disable valid",  32'(valid_o),  32'd0);
    checkOutput("disable locked", 32'(locked_o), 32'd0);
    checkOutput("disable lost",   32'(lost_o),   32'd0);
    checkOutput("disable period", 32'(period_o), 32'd10);
    checkOutput("disable high",   32'(high_o),   32'd3);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("idle valid",  32'(valid_o),  32'd0);
      checkOutput("idle period", 32'(period_o), 32'd10);
    end

    // Re-enable: two rises are needed before the next report
    applyStimulus(1'b1, 1'b0);
    runPeriod("reen1", 3, 7, 1'b0, 0, 0, 1'b0, 1'b0);
    runPeriod("reen2", 3, 7, 1'b1, 10, 3, 1'b1, 1'b0);

    // Async reset right after an update while valid_o is high
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("preReset valid",  32'(valid_o),  32'd1);
    checkOutput("preReset period", 32'(period_o), 32'd10);
    #1 rst_i = 1'b1;
    #1 checkZero("asyncReset");
    #1 rst_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("postReset valid",  32'(valid_o),  32'd0);
      checkOutput("postReset period", 32'(period_o), 32'd0);
    end
    runPeriod("relock1", 3, 7, 1'b0, 0, 0, 1'b0, 1'b0);
    runPeriod("relock2", 3, 7, 1'b1, 10, 3, 1'b1, 1'b0);

    // Never-started input: ARM entered at call 1, loss TIMEOUT+1 edges later
    #1 rst_i = 1'b1;
    #1 rst_i = 1'b0;
    for (int k = 1; k <= 105; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("noSig lost",  32'(lost_o),  32'((k >= 102) ? 1 : 0));
      checkOutput("noSig valid", 32'(valid_o), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
